arith_unit_pipe: RTL and testbench



---
 rtl/arith_unit_pipe.sv | 165 ++++++++++++++++
 tb/tb_arith_unit_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/arith_unit_pipe.sv
// Two-stage pipelined signed arithmetic unit with saturation, sticky overflow flags and a MAC accumulator.
// Optional: define ARITH_UNIT_ROUND_EN for round-half-up on MUL/MAC outputs (default: truncating shift).
module arith_unit_pipe #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40,
  parameter int FRAC_BITS = 15
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OpCode,
  input  logic             ClrOvf,
  output logic [WIDTH-1:0] Result,
  output logic             OutValid,
  output logic             Overflow,
  output logic             AccOverflow
);

  typedef enum logic [2:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_MUL     = 3'b010,
    OP_MAC     = 3'b011,
    OP_ABSDIFF = 3'b100,
    OP_MIN     = 3'b101,
    OP_MAX     = 3'b110,
    OP_CLRACC  = 3'b111
  } op_e;

  // Internal width covers the accumulator plus headroom for rounding and sign.
  localparam int IW = ACC_WIDTH + 2;

  localparam logic signed [IW-1:0] RES_MAX = {{(IW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [IW-1:0] RES_MIN = {{(IW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] ACC_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};

`ifdef ARITH_UNIT_ROUND_EN
  localparam logic signed [IW-1:0] RND = ({{(IW-1){1'b0}}, 1'b1} << FRAC_BITS) >> 1;
`else
  localparam logic signed [IW-1:0] RND = '0;
`endif

  // Stage 1 registers
  logic signed [WIDTH-1:0] a_q, b_q;
  op_e                     op_q;
  logic                    v_q;

  // NOTE: every clocked assignment is non-blocking so both stages see the pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      v_q  <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_ADD;
    end else begin
      v_q <= InValid;
      if (InValid) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= op_e'(OpCode);
      end
    end
  end

  logic signed [ACC_WIDTH-1:0] acc;

  logic signed [2*WIDTH-1:0] a_x, b_x, prod;
  logic signed [IW-1:0]      a_i, b_i, diff, prod_i, acc_i;
  logic signed [ACC_WIDTH:0] acc_sum;
  logic signed [ACC_WIDTH-1:0] acc_sat;
  logic                      acc_hit;

  assign a_x  = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_x  = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod = a_x * b_x;

  assign a_i    = {{(IW-WIDTH){a_q[WIDTH-1]}}, a_q};
  assign b_i    = {{(IW-WIDTH){b_q[WIDTH-1]}}, b_q};
  assign diff   = a_i - b_i;
  assign prod_i = {{(IW-2*WIDTH){prod[2*WIDTH-1]}}, prod};

  // The accumulator clamps rather than wraps; the sum carries one guard bit.
  assign acc_sum = {acc[ACC_WIDTH-1], acc}
                 + {{(ACC_WIDTH+1-2*WIDTH){prod[2*WIDTH-1]}}, prod};

  always_comb begin
    acc_hit = 1'b0;
    acc_sat = acc_sum[ACC_WIDTH-1:0];
    if (acc_sum > ACC_MAX) begin
      acc_hit = 1'b1;
      acc_sat = ACC_MAX[ACC_WIDTH-1:0];
    end else if (acc_sum < ACC_MIN) begin
      acc_hit = 1'b1;
      acc_sat = ACC_MIN[ACC_WIDTH-1:0];
    end
  end

  assign acc_i = {{(IW-ACC_WIDTH){acc_sat[ACC_WIDTH-1]}}, acc_sat};

  logic signed [IW-1:0]       pre;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic                       acc_ovf_hit;
  logic [WIDTH-1:0]           res_sat;
  logic                       sat_hit;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    pre         = '0;
    acc_next    = acc;
    acc_ovf_hit = 1'b0;
    unique case (op_q)
      OP_ADD:     pre = a_i + b_i;
      OP_SUB:     pre = diff;
      OP_MUL:     pre = (prod_i + RND) >>> FRAC_BITS;
      OP_MAC: begin
        acc_next    = acc_sat;
        acc_ovf_hit = acc_hit;
        pre         = (acc_i + RND) >>> FRAC_BITS;
      end
      OP_ABSDIFF: pre = diff[IW-1] ? -diff : diff;
      OP_MIN:     pre = (a_q < b_q) ? a_i : b_i;
      OP_MAX:     pre = (a_q > b_q) ? a_i : b_i;
      OP_CLRACC: begin
        acc_next = '0;
        pre      = '0;
      end
      default:    pre = '0;
    endcase

    sat_hit = 1'b0;
    res_sat = pre[WIDTH-1:0];
    if (pre > RES_MAX) begin
      sat_hit = 1'b1;
      res_sat = RES_MAX[WIDTH-1:0];
    end else if (pre < RES_MIN) begin
      sat_hit = 1'b1;
      res_sat = RES_MIN[WIDTH-1:0];
    end
  end

  // Stage 2: result, accumulator and sticky flags; a new saturation beats ClrOvf.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      acc         <= '0;
      Result      <= '0;
      OutValid    <= 1'b0;
      Overflow    <= 1'b0;
      AccOverflow <= 1'b0;
    end else begin
      OutValid <= v_q;
      if (v_q) begin
        Result <= res_sat;
        acc    <= acc_next;
      end
      if (v_q && sat_hit)          Overflow <= 1'b1;
      else if (ClrOvf)             Overflow <= 1'b0;
      if (v_q && acc_ovf_hit)      AccOverflow <= 1'b1;
      else if (ClrOvf)             AccOverflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arith_unit_pipe.sv
// Self-checking bench for arith_unit_pipe: vector table plus hand-written MAC, flag and reset sequences.
// Expected results are queued at issue time and compared when OutValid appears.
module tb_arith_unit_pipe;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, MAC = 3'b011,
                         ABSD = 3'b100, MIN = 3'b101, MAX = 3'b110, CLRA = 3'b111;

  logic        Clk = 1'b0;
  logic        Reset, InValid, ClrOvf;
  logic [15:0] A, B;
  logic [2:0]  OpCode;
  logic [15:0] Result;
  logic        OutValid, Overflow, AccOverflow;

  arith_unit_pipe #(.WIDTH(16), .ACC_WIDTH(40), .FRAC_BITS(15)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .A(A), .B(B), .OpCode(OpCode),
    .ClrOvf(ClrOvf), .Result(Result), .OutValid(OutValid), .Overflow(Overflow),
    .AccOverflow(AccOverflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        accovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic m_ovf = 1'b0;
  logic m_accovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  // Output monitor: every OutValid must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (OutValid) begin
      if (sb.size() == 0) begin
        check("unexpected_outvalid", 32'(OutValid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 32'(Result), 32'(e.res));
        check("overflow", 32'(Overflow), 32'(e.ovf));
        check("accovf", 32'(AccOverflow), 32'(e.accovf));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] res, input logic sat, input logic accsat);
    exp_t e;
    InValid = 1'b1;
    OpCode  = op;
    A       = a;
    B       = b;
    m_ovf    = m_ovf | sat;
    m_accovf = m_accovf | accsat;
    e.res = res;
    e.ovf = m_ovf;
    e.accovf = m_accovf;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    InValid = 1'b0;
  endtask

  task automatic clr_flags();
    ClrOvf = 1'b1;
    @(posedge Clk);
    #1;
    ClrOvf   = 1'b0;
    m_ovf    = 1'b0;
    m_accovf = 1'b0;
    @(negedge Clk);
    check("ovf_cleared", 32'(Overflow), 32'd0);
    check("accovf_cleared", 32'(AccOverflow), 32'd0);
    #1;
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{ADD,  16'h7000, 16'h2000, 16'h7FFF, 1'b1};
    vecs[1]  = '{ADD,  16'h8000, 16'hFFFF, 16'h8000, 1'b1};
    vecs[2]  = '{ADD,  16'h1234, 16'h0001, 16'h1235, 1'b0};
    vecs[3]  = '{SUB,  16'h0005, 16'h0007, 16'hFFFE, 1'b0};
    vecs[4]  = '{MUL,  16'h4000, 16'h4000, 16'h2000, 1'b0};
    vecs[5]  = '{MUL,  16'h8000, 16'h8000, 16'h7FFF, 1'b1};
`ifdef ARITH_UNIT_ROUND_EN
    vecs[6]  = '{MUL,  16'h0001, 16'h4000, 16'h0001, 1'b0};
    vecs[7]  = '{MUL,  16'hFFFF, 16'h0001, 16'h0000, 1'b0};
`else
    vecs[6]  = '{MUL,  16'h0001, 16'h4000, 16'h0000, 1'b0};
    vecs[7]  = '{MUL,  16'hFFFF, 16'h0001, 16'hFFFF, 1'b0};
`endif
    vecs[8]  = '{MIN,  16'hFFFE, 16'h0003, 16'hFFFE, 1'b0};
    vecs[9]  = '{MAX,  16'hFFFE, 16'h0003, 16'h0003, 1'b0};
    vecs[10] = '{ABSD, 16'hFFFE, 16'h0003, 16'h0005, 1'b0};
    vecs[11] = '{ABSD, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b1};
    vecs[12] = '{CLRA, 16'h1111, 16'h2222, 16'h0000, 1'b0};

    Reset = 1'b0; InValid = 1'b0; ClrOvf = 1'b0;
    A = '0; B = '0; OpCode = '0;
    idle(3);
    @(negedge Clk);
    check("rst_result", 32'(Result), 32'd0);
    check("rst_outvalid", 32'(OutValid), 32'd0);
    check("rst_ovf", 32'(Overflow), 32'd0);
    check("rst_accovf", 32'(AccOverflow), 32'd0);
    #1;
    Reset = 1'b1;
    idle(1);

    // Table: one op at a time, flags cleared between vectors.
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, 1'b0);
      idle(2);
      clr_flags();
    end

    // ClrOvf on the same edge as a new saturation: set wins.
    issue(ADD, 16'h7000, 16'h2000, 16'h7FFF, 1'b1, 1'b0);
    ClrOvf = 1'b1;
    idle(1);
    ClrOvf = 1'b0;
    idle(1);
    @(negedge Clk);
    check("set_wins_ovf", 32'(Overflow), 32'd1);
    #1;
    clr_flags();

    // Back-to-back MACs after CLRACC, no hazard bubble.
    issue(CLRA, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    issue(MAC, 16'h4000, 16'h4000, 16'h2000, 1'b0, 1'b0);
    issue(MAC, 16'h4000, 16'h4000, 16'h4000, 1'b0, 1'b0);
    issue(MAC, 16'h4000, 16'h4000, 16'h6000, 1'b0, 1'b0);
    idle(3);
    @(negedge Clk);
    check("hold_result", 32'(Result), 32'h6000);
    check("hold_outvalid", 32'(OutValid), 32'd0);
    #1;

    // Reset one cycle after issuing a MAC: the MAC is discarded and acc cleared.
    InValid = 1'b1; OpCode = MAC; A = 16'h4000; B = 16'h4000;
    idle(1);
    InValid = 1'b0;
    Reset   = 1'b0;
    idle(1);
    Reset    = 1'b1;
    m_ovf    = 1'b0;
    m_accovf = 1'b0;
    @(negedge Clk);
    check("midrst_outvalid", 32'(OutValid), 32'd0);
    check("midrst_result", 32'(Result), 32'd0);
    #1;
    idle(2);
    issue(MAC, 16'h4000, 16'h4000, 16'h2000, 1'b0, 1'b0);
    idle(2);

    // Accumulator saturation: 2^30 per MAC reaches the 40-bit limit on the 512th.
    issue(CLRA, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    for (int n = 1; n <= 520; n++)
      issue(MAC, 16'h8000, 16'h8000, 16'h7FFF, 1'b1, (n >= 512));
    idle(3);
    @(negedge Clk);
    check("acc_sat_flag", 32'(AccOverflow), 32'd1);
    #1;
    clr_flags();
    issue(CLRA, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    issue(MAC, 16'h4000, 16'h4000, 16'h2000, 1'b0, 1'b0);

    idle(4);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
